// File: rtl/sd_tx_dma_reader_if.sv
// sd_tx_dma_reader_if: Wishbone read-master bus between the DMA reader and memory.
interface sd_tx_dma_reader_if;
  logic [31:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_i;
  logic        m_wb_we_o;
  logic        m_wb_cyc_o;
  logic        m_wb_stb_o;
  logic        m_wb_ack_i;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o;
  modport master (
    output m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    input  m_wb_dat_i, m_wb_ack_i
  );
  modport slave (
    input  m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    output m_wb_dat_i, m_wb_ack_i
  );
endinterface

// File: rtl/sd_tx_dma_reader.sv
// sd_tx_dma_reader: fetches a 512-byte block over Wishbone into a FWFT TX FIFO.
// Define SD_TX_UNDERRUN_EN to build the sticky underrun flag; otherwise it is tied 0.
module sd_tx_dma_reader #(
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_STEP   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  sd_tx_dma_reader_if.master         m_wb,
  input  logic                       en,
  input  logic [31:0]                adr,
  input  logic                       rd,
  output logic [31:0]                dat_o,
  output logic                       empty,
  output logic                       underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nx;
  logic [8:0]    offset;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [AW:0]   count, count_nx;
  logic          push, pop;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = !en ? IDLE :
               state == IDLE ? (count < FULL ? READ : IDLE) :
               (m_wb.m_wb_ack_i ? IDLE : READ);
  always_comb begin
    m_wb.m_wb_cyc_o = state == READ;
    m_wb.m_wb_stb_o = state == READ;
    m_wb.m_wb_we_o  = 1'b0;
    m_wb.m_wb_cti_o = 3'b000;
    m_wb.m_wb_bte_o = 2'b00;
    m_wb.m_wb_adr_o = adr + {23'd0, offset};
  end
  assign push      = state == READ && m_wb.m_wb_ack_i && en;
  assign pop       = rd && !empty && en;
  assign empty     = count == '0;
  assign rd_ptr_nx = rd_ptr + AW'(pop);
  assign count_nx  = count + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk)
    if (push && !rst) mem[wr_ptr] <= m_wb.m_wb_dat_i;
  always_ff @(posedge clk)
    if (rst || !en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      offset <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      offset <= offset + (push ? 9'(MEM_STEP) : 9'd0);
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
    end
  // The new head may be the very word being written on this edge.
  always_ff @(posedge clk)
    if (rst) dat_o <= '0;
    else if (en && count_nx != '0)
      dat_o <= (push && rd_ptr_nx == wr_ptr) ? m_wb.m_wb_dat_i : mem[rd_ptr_nx];
`ifdef SD_TX_UNDERRUN_EN
  always_ff @(posedge clk)
    if (rst || !en) underrun <= 1'b0;
    else if (rd && empty) underrun <= 1'b1;
`else
  assign underrun = 1'b0;
`endif
endmodule

// File: tb/tb_sd_tx_dma_reader.sv
// tb_sd_tx_dma_reader: scoreboard bench for the SD TX DMA reader.
module tb_sd_tx_dma_reader;
`ifdef SD_TX_UNDERRUN_EN
  localparam logic UR = 1'b1;
`else
  localparam logic UR = 1'b0;
`endif
  logic clk = 0, rst, en, rd, slave_en, force_ack, slave_ack = 0, seen = 0;
  logic [31:0] adr, dat_o;
  logic empty, underrun;
  int checks = 0, errors = 0;
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  sd_tx_dma_reader_if bus();
  sd_tx_dma_reader dut (
    .clk(clk), .rst(rst), .m_wb(bus), .en(en), .adr(adr), .rd(rd),
    .dat_o(dat_o), .empty(empty), .underrun(underrun)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] data_of(logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction
  assign bus.m_wb_dat_i = data_of(bus.m_wb_adr_o);
  assign bus.m_wb_ack_i = slave_ack | force_ack;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic wait_drain(int budget);
    int n = 0;
    while (exp_adr.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("reads_done", exp_adr.size(), 0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_cyc", {31'd0, bus.m_wb_cyc_o}, 0);
    chk("rst_stb", {31'd0, bus.m_wb_stb_o}, 0);
    chk("rst_we", {31'd0, bus.m_wb_we_o}, 0);
    chk("rst_cti", {29'd0, bus.m_wb_cti_o}, 0);
    chk("rst_bte", {30'd0, bus.m_wb_bte_o}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_dat", dat_o, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_adr", bus.m_wb_adr_o, 32'h1000);
  endtask
  // Slave: acks in the cycle after strobe first appears.
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.m_wb_cyc_o) begin
      slave_ack = seen && slave_en;
      seen = 1;
    end else begin
      slave_ack = 0;
      seen = 0;
    end
  end
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.m_wb_cyc_o && bus.m_wb_ack_i && en && !rst) begin
      if (exp_adr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%h expected=none", bus.m_wb_adr_o);
      end else begin
        e = exp_adr.pop_front();
        chk("read_adr", bus.m_wb_adr_o, e);
        exp_dat.push_back(data_of(e));
      end
    end
  end
  always @(negedge clk) begin
    logic [31:0] e;
    if (rd && !empty && en && !rst) begin
      if (exp_dat.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual=%h expected=none", dat_o);
      end else begin
        e = exp_dat.pop_front();
        chk("pop_dat", dat_o, e);
      end
    end
  end
  initial begin
    rst = 1; en = 0; rd = 0; adr = 32'h1000; slave_en = 1; force_ack = 0;
    tick(2);
    chk_reset_vals();
    rst = 0;
    tick(1);
    for (int i = 0; i < 8; i++) exp_adr.push_back(32'h1000 + 4 * i);
    en = 1;
    wait_drain(100);
    tick(10);
    chk("full_cyc_low", {31'd0, bus.m_wb_cyc_o}, 0);
    chk("full_not_empty", {31'd0, empty}, 0);
    chk("fwft_head", dat_o, data_of(32'h1000));
    exp_adr.push_back(32'h1020);
    rd = 1;
    tick(1);
    rd = 0;
    chk("after_pop_head", dat_o, data_of(32'h1004));
    wait_drain(50);
    tick(4);
    chk("refull_cyc_low", {31'd0, bus.m_wb_cyc_o}, 0);
    for (int i = 10; i <= 129; i++) exp_adr.push_back(32'h1000 + ((4 * (i - 1)) % 512));
    rd = 1;
    wait_drain(1000);
    slave_en = 0;
    rd = 0;
    tick(3);
    chk("stall_cyc_high", {31'd0, bus.m_wb_cyc_o}, 1);
    en = 0;
    force_ack = 1;
    tick(1);
    force_ack = 0;
    exp_dat.delete();
    chk("abort_cyc", {31'd0, bus.m_wb_cyc_o}, 0);
    chk("abort_empty", {31'd0, empty}, 1);
    chk("abort_underrun", {31'd0, underrun}, 0);
    chk("abort_adr", bus.m_wb_adr_o, 32'h1000);
    for (int i = 0; i < 8; i++) exp_adr.push_back(32'h1000 + 4 * i);
    en = 1;
    slave_en = 1;
    wait_drain(100);
    tick(2);
    chk("abort_word_dropped", dat_o, data_of(32'h1000));
    en = 0;
    tick(1);
    exp_dat.delete();
    chk("flush_empty", {31'd0, empty}, 1);
    en = 1;
    slave_en = 0;
    tick(1);
    rd = 1;
    tick(1);
    rd = 0;
    chk("underrun_set", {31'd0, underrun}, {31'd0, UR});
    tick(3);
    chk("underrun_sticky", {31'd0, underrun}, {31'd0, UR});
    en = 0;
    tick(1);
    chk("underrun_clear", {31'd0, underrun}, 0);
    slave_en = 1;
    exp_adr.push_back(32'h1000);
    exp_adr.push_back(32'h1004);
    en = 1;
    wait_drain(50);
    slave_en = 0;
    tick(3);
    chk("pre_rst_stb", {31'd0, bus.m_wb_stb_o}, 1);
    chk("pre_rst_head", dat_o, data_of(32'h1000));
    rst = 1;
    force_ack = 1;
    rd = 1;
    tick(1);
    rst = 0;
    en = 0;
    force_ack = 0;
    rd = 0;
    exp_dat.delete();
    chk_reset_vals();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_tx_dma_reader.md
SD_TX_DMA_READER -- requirements
Module: sd_tx_dma_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX FIFO depth in 32-bit words; SHALL be a power of two, 2 to 64.
REQ-002 Parameter MEM_STEP, default 4, byte increment added to the address offset per completed read.
REQ-003 clk  input  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 m_wb_adr_o  output  32  read address, equal to adr + offset, with offset zero-extended.
REQ-006 m_wb_we_o  output  1  held 0; reads only.
REQ-007 m_wb_dat_i  input  32  read data, valid when m_wb_ack_i=1.
REQ-008 m_wb_cyc_o, m_wb_stb_o  output  1 each  cycle and strobe, always asserted and deasserted together.
REQ-009 m_wb_ack_i  input  1  slave acknowledge.
REQ-010 m_wb_cti_o  output  3  held 3'b000; m_wb_bte_o  output  2  held 2'b00.
REQ-011 en  input  1  transfer enable; low aborts the transfer and flushes the block.
REQ-012 adr  input  32  buffer base byte address, stable while en=1.
REQ-013 rd  input  1  serial-side pop request.
REQ-014 dat_o  output  32  head word of the FIFO (first-word-fall-through).
REQ-015 empty  output  1  FIFO holds no words.
REQ-016 underrun  output  1  sticky flag, set by rd=1 while empty=1.

Function
REQ-017 Two-state FSM, IDLE and READ; cyc/stb SHALL be 1 exactly when the state is READ.
REQ-018 IDLE->READ on an edge where en=1, rst=0 and FIFO count < FIFO_DEPTH.
REQ-019 On that same edge, m_wb_adr_o SHALL present adr + offset.
REQ-020 READ holds cyc/stb and the address until an edge with m_wb_ack_i=1.
REQ-021 On that ack edge, the block SHALL:
- write m_wb_dat_i into the FIFO;
- add MEM_STEP to offset;
- return to IDLE, dropping cyc/stb.
REQ-022 At most one read is outstanding; consecutive requests have at least one IDLE cycle between them.
REQ-023 offset is 9 bits and SHALL wrap from 508 to 0 (512-byte block), with no carry into adr.
REQ-024 m_wb_ack_i while in IDLE SHALL be ignored.
REQ-025 FIFO full (count = FIFO_DEPTH): the FSM SHALL stay in IDLE until a pop frees space.
REQ-026 rd=1 with empty=0: pop on that edge; dat_o SHALL show the next word (or hold if empty) in the following cycle.
REQ-027 rd=1 with empty=1: no pointer change; dat_o holds its value.
REQ-028 Simultaneous push (ack) and pop in the same edge: both SHALL occur and count SHALL be unchanged.
REQ-029 A push into an empty FIFO on edge N SHALL deassert empty after edge N.
REQ-030 en=0 on any edge, including mid-READ, SHALL next cycle:
- drop cyc/stb and go to IDLE;
- zero offset;
- flush the FIFO (empty=1);
- discard any ack arriving on that edge.

Reset
REQ-031 On a rst edge:
- FSM to IDLE, with cyc/stb/we=0, cti=000, bte=00;
- offset=0, FIFO pointers and count=0, empty=1;
- dat_o=0 and underrun=0.
REQ-032 rst SHALL take priority over en, ack and rd on the same edge.

Configuration
REQ-033 Macro SD_TX_UNDERRUN_EN defined: underrun SHALL set on any edge with rd=1 and empty=1, and clear only on rst or en=0.
REQ-034 Macro SD_TX_UNDERRUN_EN undefined: underrun SHALL be tied 0 and no flag logic is synthesised; all other behaviour is identical.

Verification
REQ-035 Fill:
- stimulus: adr=0x1000, en=1, slave acks 1 cycle after stb, rd=0;
- response: exactly 8 reads at 0x1000..0x101C, then cyc stays 0 and FIFO holds 8 words.
REQ-036 Drain in order:
- stimulus: after REQ-035, pop once;
- response: dat_o shows the word read from 0x1000, then 0x1004; the next read issues at 0x1020.
REQ-037 Wrap:
- stimulus: continuous rd with words available, 129 reads;
- response: the 129th address is adr+0, and offset wraps after 0x1FC.
REQ-038 Abort:
- stimulus: en dropped while cyc=1, with ack asserted on the same edge;
- response: next cycle cyc=0, empty=1, offset=0, and the word is not stored.
REQ-039 Underrun (macro defined):
- stimulus: rd=1 while empty;
- response: underrun=1 the next cycle, and it stays 1 until en=0.
- With the macro undefined, underrun stays 0.
REQ-040 Reset mid-READ:
- stimulus: rst=1 while stb=1;
- response: all outputs at the REQ-031 reset values after that edge.
